// File: rtl/mem_stage_if_if.sv
// Bus between the memory-stage sequencer (master) and mem_system (slave).
interface mem_stage_if_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;

    modport master (
        output Addr, DataIn, Rd, Wr,
        input  DataOut, Done, Stall, CacheHit, err
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr,
        output DataOut, Done, Stall, CacheHit, err
    );
endinterface

// File: rtl/mem_stage_if.sv
// mem_stage_if: holds one pipeline load/store stable on the mem_system bus until Done.
// Optional access/hit statistics are built only when MEM_IF_STATS_EN is defined.
module mem_stage_if #(
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    input  logic           req_wr,
    input  logic [15:0]    req_addr,
    input  logic [15:0]    req_wdata,
    output logic           proc_stall,
    output logic [15:0]    rd_data,
    output logic           rd_valid,
    output logic           req_err,
    mem_stage_if_if.master mem,
    output logic [15:0]    acc_count,
    output logic [15:0]    hit_count
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_FAULT} state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_rd;
    logic        r_wr;
    logic        r_held_wr;
    logic        r_rd_valid;
    logic        r_req_err;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rd_data;
    logic [7:0]  r_tcnt;

    logic w_accepting;
    logic w_req_ok;
    logic w_req_bad;
    logic w_done_ok;
    logic w_unused;

    // Gating with rst keeps proc_stall low while reset is held, even with req_valid up.
    assign w_accepting = ((r_state == S_IDLE) || (r_state == S_RESP)) && !rst;
    assign w_req_ok    = w_accepting && req_valid && !req_addr[0];
    assign w_req_bad   = w_accepting && req_valid && req_addr[0];
    assign w_done_ok   = (r_state == S_BUSY) && mem.Done && !mem.err;
    assign proc_stall  = w_req_ok || (r_state == S_BUSY) || (r_state == S_FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_held_wr  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_req_err  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_tcnt     <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            r_req_err  <= 1'b0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_req_ok) begin
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_held_wr <= req_wr;
                        r_rd      <= !req_wr;
                        r_wr      <= req_wr;
                        r_tcnt    <= '0;
                        r_state   <= S_BUSY;
                    end else if (w_req_bad) begin
                        r_req_err <= 1'b1;
                        r_state   <= S_FAULT;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    // err outranks Done; Done in the last budgeted cycle still completes.
                    if (mem.err) begin
                        r_rd      <= 1'b0;
                        r_wr      <= 1'b0;
                        r_req_err <= 1'b1;
                        r_state   <= S_FAULT;
                    end else if (mem.Done) begin
                        if (!r_held_wr) begin
                            r_rd_data <= mem.DataOut;
                        end
                        r_rd_valid <= !r_held_wr;
                        r_rd       <= 1'b0;
                        r_wr       <= 1'b0;
                        r_state    <= S_RESP;
                    end else if (r_tcnt == TLAST) begin
                        r_rd      <= 1'b0;
                        r_wr      <= 1'b0;
                        r_req_err <= 1'b1;
                        r_state   <= S_FAULT;
                    end else begin
                        r_tcnt    <= r_tcnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.Rd     = r_rd;
    assign mem.Wr     = r_wr;
    assign mem.Addr   = r_addr;
    assign mem.DataIn = r_wdata;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign req_err    = r_req_err;

`ifdef MEM_IF_STATS_EN
    logic [15:0] r_acc_count;
    logic [15:0] r_hit_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_count <= '0;
            r_hit_count <= '0;
        end else if (w_done_ok) begin
            if (r_acc_count != 16'hFFFF) begin
                r_acc_count <= r_acc_count + 16'd1;
            end
            if (mem.CacheHit && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
        end
    end

    assign acc_count = r_acc_count;
    assign hit_count = r_hit_count;
    assign w_unused  = mem.Stall;
`else
    assign acc_count = 16'h0000;
    assign hit_count = 16'h0000;
    assign w_unused  = mem.Stall ^ mem.CacheHit ^ w_done_ok;
`endif

endmodule

// File: tb/tb_mem_stage_if.sv
// Directed plus randomized bench for mem_stage_if against a transaction-level model.
module tb_mem_stage_if;
    localparam int T = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        proc_stall;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        req_err;
    logic [15:0] acc_count;
    logic [15:0] hit_count;

    mem_stage_if_if mbus();

    mem_stage_if #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .proc_stall (proc_stall),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .req_err    (req_err),
        .mem        (mbus),
        .acc_count  (acc_count),
        .hit_count  (hit_count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_rd_data;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic [15:0] exp_acc;
    logic [15:0] exp_hit;
    bit          last_resp;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic idle_check(input string tag);
        chk1({tag, "_rd"}, mbus.Rd, 1'b0);
        chk1({tag, "_wr"}, mbus.Wr, 1'b0);
        chk1({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk1({tag, "_req_err"}, req_err, 1'b0);
        chk1({tag, "_stall"}, proc_stall, 1'b0);
        chk16({tag, "_rd_data"}, rd_data, exp_rd_data);
        chk16({tag, "_addr"}, mbus.Addr, exp_addr);
        chk16({tag, "_datain"}, mbus.DataIn, exp_wdata);
    endtask

    task automatic stat_check(input string tag);
`ifdef MEM_IF_STATS_EN
        chk16({tag, "_acc"}, acc_count, exp_acc);
        chk16({tag, "_hit"}, hit_count, exp_hit);
`else
        chk16({tag, "_acc"}, acc_count, 16'h0000);
        chk16({tag, "_hit"}, hit_count, 16'h0000);
`endif
    endtask

    // One request: lat = BUSY cycle carrying Done, errc = BUSY cycle carrying err (0 = none).
    task automatic xact(input string tag, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input int lat, input int errc,
                        input bit hit, input logic [15:0] data, input bit b2b);
        int busy;
        bit fault;
        if (!b2b) begin
            @(negedge clk);
            #1;
            idle_check({tag, "_pre"});
        end
        req_valid     = 1'b1;
        req_wr        = wr;
        req_addr      = addr;
        req_wdata     = wdata;
        mbus.Done     = 1'b0;
        mbus.err      = 1'b0;
        mbus.CacheHit = hit;
        #1;
        chk1({tag, "_stall_c0"}, proc_stall, !addr[0]);
        if (addr[0]) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            chk1({tag, "_mis_err"}, req_err, 1'b1);
            chk1({tag, "_mis_stall"}, proc_stall, 1'b1);
            chk1({tag, "_mis_rd"}, mbus.Rd, 1'b0);
            chk1({tag, "_mis_wr"}, mbus.Wr, 1'b0);
            chk1({tag, "_mis_rdv"}, rd_valid, 1'b0);
            chk16({tag, "_mis_addr"}, mbus.Addr, exp_addr);
            last_resp = 1'b0;
            return;
        end
        exp_addr  = addr;
        exp_wdata = wdata;
        busy  = (lat < T) ? lat : T;
        fault = 1'b0;
        if (errc != 0 && errc <= busy) begin
            busy  = errc;
            fault = 1'b1;
        end else if (lat > T) begin
            fault = 1'b1;
        end
        for (int k = 1; k <= busy; k++) begin
            @(negedge clk);
            req_valid     = 1'b0;
            req_addr      = 16'($urandom);
            req_wdata     = 16'($urandom);
            mbus.Stall    = 1'($urandom_range(0, 1));
            mbus.Done     = (k == lat);
            mbus.err      = (k == errc);
            mbus.DataOut  = (k == lat) ? data : 16'($urandom);
            #1;
            chk1({tag, "_busy_rd"}, mbus.Rd, !wr);
            chk1({tag, "_busy_wr"}, mbus.Wr, wr);
            chk16({tag, "_busy_addr"}, mbus.Addr, addr);
            chk16({tag, "_busy_din"}, mbus.DataIn, wdata);
            chk1({tag, "_busy_stall"}, proc_stall, 1'b1);
            chk1({tag, "_busy_rdv"}, rd_valid, 1'b0);
            chk1({tag, "_busy_err"}, req_err, 1'b0);
        end
        @(negedge clk);
        mbus.Done = 1'b0;
        mbus.err  = 1'b0;
        #1;
        if (!fault && !wr) exp_rd_data = data;
        if (!fault) begin
            if (exp_acc != 16'hFFFF) exp_acc++;
            if (hit && exp_hit != 16'hFFFF) exp_hit++;
        end
        chk1({tag, "_out_rd"}, mbus.Rd, 1'b0);
        chk1({tag, "_out_wr"}, mbus.Wr, 1'b0);
        chk1({tag, "_out_err"}, req_err, fault);
        chk1({tag, "_out_rdv"}, rd_valid, !fault && !wr);
        chk16({tag, "_out_rdata"}, rd_data, exp_rd_data);
        chk1({tag, "_out_stall"}, proc_stall, fault);
        chk16({tag, "_out_addr"}, mbus.Addr, addr);
        chk16({tag, "_out_din"}, mbus.DataIn, wdata);
        last_resp = !fault;
    endtask

    initial begin
        bit          r_wr;
        bit          r_hit;
        bit          r_b2b;
        logic [15:0] r_addr;
        int          r_lat;
        int          r_errc;

        rst           = 1'b1;
        req_valid     = 1'b0;
        req_wr        = 1'b0;
        req_addr      = 16'h0000;
        req_wdata     = 16'h0000;
        mbus.DataOut  = 16'h0000;
        mbus.Done     = 1'b0;
        mbus.Stall    = 1'b0;
        mbus.CacheHit = 1'b0;
        mbus.err      = 1'b0;
        exp_rd_data   = 16'h0000;
        exp_addr      = 16'h0000;
        exp_wdata     = 16'h0000;
        exp_acc       = 16'h0000;
        exp_hit       = 16'h0000;
        last_resp     = 1'b0;
        #1;
        idle_check("reset");
        stat_check("reset");
        @(negedge clk);
        rst = 1'b0;

        xact("load_hit", 1'b0, 16'h0010, 16'h0000, 1, 0, 1'b1, 16'hBEEF, 1'b0);
        xact("store_miss", 1'b1, 16'h0200, 16'h1234, 10, 0, 1'b0, 16'h0000, 1'b0);
        xact("misalign", 1'b0, 16'h0011, 16'h0000, 1, 0, 1'b0, 16'h0000, 1'b0);
        xact("timeout", 1'b0, 16'h0040, 16'h0000, 1000, 0, 1'b0, 16'h0000, 1'b0);
        xact("err_done", 1'b0, 16'h0042, 16'h0000, 3, 3, 1'b1, 16'hDEAD, 1'b0);
        stat_check("directed");

        // Reset asserted in the middle of a BUSY load, checked before the next edge.
        @(negedge clk);
        #1;
        idle_check("prerst");
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 16'h0080;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk1("rstbusy_rd", mbus.Rd, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        exp_rd_data = 16'h0000;
        exp_addr    = 16'h0000;
        exp_wdata   = 16'h0000;
        exp_acc     = 16'h0000;
        exp_hit     = 16'h0000;
        idle_check("async_rst");
        stat_check("async_rst");
        @(negedge clk);
        rst = 1'b0;

        xact("b2b_hit", 1'b0, 16'h0100, 16'h0000, 1, 0, 1'b1, 16'h1111, 1'b0);
        xact("b2b_miss", 1'b0, 16'h0102, 16'h0000, 4, 0, 1'b0, 16'h2222, 1'b1);
        stat_check("b2b");

        for (int n = 0; n < 40; n++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = 16'($urandom);
            if ($urandom_range(0, 3) != 0) r_addr[0] = 1'b0;
            r_lat  = int'($urandom_range(1, T + 3));
            r_errc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : 0;
            r_hit  = 1'($urandom_range(0, 1));
            r_b2b  = last_resp && ($urandom_range(0, 1) == 1);
            xact("rand", r_wr, r_addr, 16'($urandom), r_lat, r_errc, r_hit,
                 16'($urandom), r_b2b);
        end

        @(negedge clk);
        #1;
        idle_check("final");
        stat_check("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage_if.md
# mem_stage_if

Request sequencer between the processor memory stage and `mem_system`. Captures one load/store from the pipeline and holds `Addr`/`DataIn`/`Rd`/`Wr` stable until `mem_system` raises `Done`. Stalls the pipeline meanwhile and returns read data with a one-cycle valid strobe. Also rejects misaligned accesses and aborts requests that exceed a cycle budget.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum cycles in BUSY without `Done` before abort; range 2..255.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: pipeline request present, held while `proc_stall`=1.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_addr` in 16: byte address.
- `req_wdata` in 16: store data.
- `proc_stall` out 1: pipeline must hold.
- `rd_data` out 16: load result, registered.
- `rd_valid` out 1: one-cycle strobe, `rd_data` is valid.
- `req_err` out 1: one-cycle strobe for misalign, memory error or timeout.
- `Addr`, `DataIn` out 16: to `mem_system`.
- `Rd`, `Wr` out 1: to `mem_system`.
- `DataOut` in 16, `Done` in 1, `Stall` in 1, `CacheHit` in 1, `err` in 1: from `mem_system`.
- `acc_count`, `hit_count` out 16: statistics (see Configuration).

## Operation
- States: IDLE, BUSY, RESP, FAULT.
- IDLE/RESP (accepting):
  - `req_valid` with `req_addr[0]`=0: latch addr/wdata/wr into holding registers, clear the timeout counter, go to BUSY.
  - `req_valid` with `req_addr[0]`=1: go to FAULT. No memory access is issued.
  - Otherwise go to IDLE.
- BUSY:
  - `Rd` = ~held_wr and `Wr` = held_wr.
  - `Addr` and `DataIn` come from the holding registers, constant for the whole state.
  - On `Done`: load `rd_data`<=`DataOut` for loads (unchanged for stores), go to RESP.
  - On `err` (with or without `Done`): go to FAULT. Error takes priority over `Done`.
  - If the counter reaches `TIMEOUT`-1 without `Done`: go to FAULT.
- RESP: `rd_valid`=1 for loads only (0 for stores). Accepts a new request this cycle, as IDLE does.
- FAULT: `req_err`=1 for one cycle, then IDLE. Does not accept requests.
- `proc_stall` = (accepting & `req_valid` & ~`req_addr[0]`) | BUSY | FAULT. The term is combinational from `req_valid`, so the pipeline holds through the capture cycle.
- `Rd`/`Wr` are 0 in every state except BUSY. `Addr`/`DataIn` hold their last value outside BUSY.
- `Stall` from `mem_system` is informational only. `Done` alone ends a request.

## Timing
- Reset (async, immediate): state IDLE; `Rd`=`Wr`=0; `proc_stall`=0; `rd_valid`=0; `req_err`=0; `rd_data`=0; `Addr`=`DataIn`=0; counters=0.
- Reset during BUSY drops `Rd`/`Wr` in the same cycle. No completion is reported.
- Minimum latency:
  - Request accepted at cycle 0.
  - `Rd`/`Wr` asserted at cycle 1.
  - `Done` at cycle 1 (same-cycle hit) gives `rd_valid` at cycle 2.
- Back-to-back requests: a request presented in RESP enters BUSY on the next cycle. Sustained rate is 1 access per 2 cycles for hits.
- Timeout: FAULT is entered exactly `TIMEOUT` cycles after BUSY entry.
- `Rd`/`Wr`/`Addr`/`DataIn` are register outputs, glitch-free.

## Configuration
- `MEM_IF_STATS_EN` defined:
  - `acc_count` increments on each BUSY->RESP transition.
  - `hit_count` increments on the same transition when `CacheHit`=1.
  - Both saturate at 16'hFFFF. Both reset to 0.
- Not defined: `acc_count`=`hit_count`=16'h0000 constant, and no counter flops are synthesized.

## Test plan
- Load hit: `req_addr`=16'h0010, `Done`=1 with `DataOut`=16'hBEEF in the first BUSY cycle -> `Rd`=1 for one cycle, `rd_valid`=1 at cycle 2 with `rd_data`=16'hBEEF, `proc_stall` high for cycles 0-1.
- Store miss: `req_wr`=1, `req_addr`=16'h0200, `req_wdata`=16'h1234, `Done` after 10 BUSY cycles -> `Wr`/`Addr`/`DataIn` stable all 10 cycles, `rd_valid` stays 0, `proc_stall` falls in RESP.
- Misaligned: `req_addr`=16'h0011 -> no `Rd`/`Wr`, `req_err` pulse one cycle later, `proc_stall` high that cycle only.
- Timeout with `TIMEOUT`=8 and `Done` never asserted -> `Rd` high for exactly 8 cycles, then `req_err` pulse, then IDLE. Memory `err` asserted together with `Done` -> `req_err`, no `rd_valid`.
- Async `rst` asserted mid-BUSY -> `Rd`=0 and `proc_stall`=0 before the next clock edge; a new load after release completes normally.
- Back-to-back loads, hit then miss, with `MEM_IF_STATS_EN` -> `acc_count`=2, `hit_count`=1. Without the macro, both read 0.
